// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared states, HD44780 command bytes and init timing for lcd_text_ctrl
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_INIT,
    ST_CONFIG,
    ST_IDLE,
    ST_SET_ADDR,
    ST_FETCH,
    ST_WRITE_CHAR
  } lcd_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SETUP,
    TX_EHIGH,
    TX_GAP,
    TX_WAIT
  } tx_state_e;

  localparam logic [7:0] CMD_FUNC_2LINE = 8'h28;
  localparam logic [7:0] CMD_FUNC_1LINE = 8'h20;
  localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
  localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_SET_DDRAM  = 8'h80;
  localparam logic [7:0] DDRAM_ROW1     = 8'h40;

  localparam int INIT_WAIT_0  = 205000;
  localparam int INIT_WAIT_1  = 5000;
  localparam int INIT_WAIT_2  = 2000;
  localparam int INIT_WAIT_3  = 2000;
  localparam int SETUP_CYCLES = 2;

  // Wake-up sequence: three 8-bit-mode nibbles, then the switch to 4-bit mode.
  function automatic logic [7:0] init_nibble(input logic [1:0] step);
    return (step == 2'd3) ? 8'h02 : 8'h03;
  endfunction

  function automatic logic [7:0] config_byte(input logic [1:0] step, input logic two_rows);
    case (step)
      2'd0:    config_byte = two_rows ? CMD_FUNC_2LINE : CMD_FUNC_1LINE;
      2'd1:    config_byte = CMD_ENTRY_MODE;
      2'd2:    config_byte = CMD_DISP_ON;
      default: config_byte = CMD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// rtl/lcd_nibble_tx.sv - one 4-bit LCD transfer (single nibble or full byte) including the post-transfer wait
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int E_PULSE  = 12,
  parameter int NIB_GAP  = 50,
  parameter int CMD_WAIT = 2000,
  parameter int CLR_WAIT = 82000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [7:0]  byte_i,
  input  logic        rs_i,
  input  logic        nibble_only_i,
  input  logic        long_wait_i,
  input  logic [31:0] nib_wait_i,
  output logic        done_o,
  output logic        lcd_e_o,
  output logic        lcd_rs_o,
  output logic [3:0]  sf_d_o
);

  localparam logic [31:0] SETUP_LAST = 32'(SETUP_CYCLES - 1);
  localparam logic [31:0] E_LAST     = 32'(E_PULSE - 1);
  localparam logic [31:0] GAP_LAST   = 32'(NIB_GAP - 1);

  tx_state_e   st_q;
  logic [31:0] cnt_q;
  logic [31:0] wait_q;
  logic [3:0]  lo_nib_q;
  logic        hi_q;
  logic        done_q;
  logic        lcd_e_q;
  logic        lcd_rs_q;
  logic [3:0]  sf_d_q;

  always_ff @(posedge clk_i) begin
    done_q <= 1'b0;
    if (reset_i) begin
      st_q     <= TX_IDLE;
      cnt_q    <= '0;
      wait_q   <= '0;
      lo_nib_q <= '0;
      hi_q     <= 1'b0;
      lcd_e_q  <= 1'b0;
      lcd_rs_q <= 1'b0;
      sf_d_q   <= '0;
    end else begin
      case (st_q)
        TX_IDLE: begin
          if (start_i) begin
            lo_nib_q <= byte_i[3:0];
            hi_q     <= ~nibble_only_i;
            sf_d_q   <= nibble_only_i ? byte_i[3:0] : byte_i[7:4];
            lcd_rs_q <= rs_i;
            wait_q   <= nibble_only_i ? nib_wait_i :
                        (long_wait_i ? 32'(CLR_WAIT) : 32'(CMD_WAIT));
            cnt_q    <= '0;
            st_q     <= TX_SETUP;
          end
        end
        TX_SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            cnt_q   <= '0;
            lcd_e_q <= 1'b1;
            st_q    <= TX_EHIGH;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        TX_EHIGH: begin
          if (cnt_q == E_LAST) begin
            cnt_q   <= '0;
            lcd_e_q <= 1'b0;
            st_q    <= hi_q ? TX_GAP : TX_WAIT;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        // High nibble stays on the bus through the gap; the low nibble loads at the next setup.
        TX_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q  <= '0;
            hi_q   <= 1'b0;
            sf_d_q <= lo_nib_q;
            st_q   <= TX_SETUP;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        TX_WAIT: begin
          if (cnt_q == wait_q - 32'd1) begin
            cnt_q  <= '0;
            done_q <= 1'b1;
            st_q   <= TX_IDLE;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: st_q <= TX_IDLE;
      endcase
    end
  end

  assign done_o   = done_q;
  assign lcd_e_o  = lcd_e_q;
  assign lcd_rs_o = lcd_rs_q;
  assign sf_d_o   = sf_d_q;

endmodule

// File: rtl/lcd_text_ctrl.sv
// rtl/lcd_text_ctrl.sv - character LCD init + screen refresh controller; LCD_AUTO_REFRESH_EN adds periodic refresh
module lcd_text_ctrl
  import lcd_pkg::*;
#(
  parameter int ROWS           = 2,
  parameter int COLS           = 16,
  parameter int ADDR_W         = 11,
  parameter int POWERUP_CYCLES = 750000,
  parameter int E_PULSE        = 12,
  parameter int NIB_GAP        = 50,
  parameter int CMD_WAIT       = 2000,
  parameter int CLR_WAIT       = 82000,
  parameter int INIT_WAIT0     = INIT_WAIT_0,
  parameter int INIT_WAIT1     = INIT_WAIT_1,
  parameter int INIT_WAIT2     = INIT_WAIT_2,
  parameter int INIT_WAIT3     = INIT_WAIT_3
`ifdef LCD_AUTO_REFRESH_EN
  , parameter int REFRESH_PERIOD = 50000000
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              refresh_req,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              busy,
  output logic              init_done,
  output logic              lcd_e,
  output logic              lcd_rs,
  output logic              lcd_rw,
  output logic [3:0]        sf_d
);

  localparam logic [31:0] POWERUP_LAST = 32'(POWERUP_CYCLES - 1);
  localparam logic        TWO_ROWS     = (ROWS == 2);

  lcd_state_e        state_q;
  logic [31:0]       cnt_q;
  logic [1:0]        step_q;
  logic              issued_q;
  logic              row_q;
  logic [5:0]        col_q;
  logic              pending_q;
  logic              busy_q;
  logic              init_done_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              tx_start_q;
  logic [7:0]        tx_byte_q;
  logic              tx_rs_q;
  logic              tx_nib_only_q;
  logic              tx_long_q;
  logic [31:0]       tx_nib_wait_q;
  logic              tx_done;
  logic              refresh_evt;

  function automatic logic [31:0] init_wait(input logic [1:0] s);
    case (s)
      2'd0:    init_wait = 32'(INIT_WAIT0);
      2'd1:    init_wait = 32'(INIT_WAIT1);
      2'd2:    init_wait = 32'(INIT_WAIT2);
      default: init_wait = 32'(INIT_WAIT3);
    endcase
  endfunction

`ifdef LCD_AUTO_REFRESH_EN
  logic [31:0] auto_cnt_q;
  logic        auto_tick_q;

  always_ff @(posedge clk) begin
    if (reset || !init_done_q) begin
      auto_cnt_q  <= '0;
      auto_tick_q <= 1'b0;
    end else if (auto_cnt_q == 32'(REFRESH_PERIOD - 1)) begin
      auto_cnt_q  <= '0;
      auto_tick_q <= 1'b1;
    end else begin
      auto_cnt_q  <= auto_cnt_q + 32'd1;
      auto_tick_q <= 1'b0;
    end
  end

  assign refresh_evt = refresh_req | auto_tick_q;
`else
  assign refresh_evt = refresh_req;
`endif

  always_ff @(posedge clk) begin
    tx_start_q <= 1'b0;
    if (reset) begin
      state_q       <= ST_POWERUP;
      cnt_q         <= '0;
      step_q        <= '0;
      issued_q      <= 1'b0;
      row_q         <= 1'b0;
      col_q         <= '0;
      pending_q     <= 1'b0;
      busy_q        <= 1'b1;
      init_done_q   <= 1'b0;
      mem_addr_q    <= '0;
      tx_byte_q     <= '0;
      tx_rs_q       <= 1'b0;
      tx_nib_only_q <= 1'b0;
      tx_long_q     <= 1'b0;
      tx_nib_wait_q <= '0;
    end else begin
      if (refresh_evt && state_q != ST_IDLE) pending_q <= 1'b1;
      case (state_q)
        ST_POWERUP: begin
          if (cnt_q == POWERUP_LAST) begin
            cnt_q   <= '0;
            step_q  <= '0;
            state_q <= ST_INIT;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        ST_INIT: begin
          if (!issued_q) begin
            issued_q      <= 1'b1;
            tx_start_q    <= 1'b1;
            tx_byte_q     <= init_nibble(step_q);
            tx_rs_q       <= 1'b0;
            tx_nib_only_q <= 1'b1;
            tx_long_q     <= 1'b0;
            tx_nib_wait_q <= init_wait(step_q);
          end else if (tx_done) begin
            issued_q <= 1'b0;
            step_q   <= step_q + 2'd1;
            if (step_q == 2'd3) state_q <= ST_CONFIG;
          end
        end
        ST_CONFIG: begin
          if (!issued_q) begin
            issued_q      <= 1'b1;
            tx_start_q    <= 1'b1;
            tx_byte_q     <= config_byte(step_q, TWO_ROWS);
            tx_rs_q       <= 1'b0;
            tx_nib_only_q <= 1'b0;
            tx_long_q     <= (config_byte(step_q, TWO_ROWS) == CMD_CLEAR);
          end else if (tx_done) begin
            issued_q <= 1'b0;
            step_q   <= step_q + 2'd1;
            if (step_q == 2'd3) begin
              init_done_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end
        end
        ST_IDLE: begin
          if (pending_q || refresh_evt) begin
            pending_q  <= 1'b0;
            busy_q     <= 1'b1;
            mem_addr_q <= base_addr;
            row_q      <= 1'b0;
            state_q    <= ST_SET_ADDR;
          end
        end
        ST_SET_ADDR: begin
          if (!issued_q) begin
            issued_q      <= 1'b1;
            tx_start_q    <= 1'b1;
            tx_byte_q     <= CMD_SET_DDRAM | (row_q ? DDRAM_ROW1 : 8'h00);
            tx_rs_q       <= 1'b0;
            tx_nib_only_q <= 1'b0;
            tx_long_q     <= 1'b0;
          end else if (tx_done) begin
            issued_q <= 1'b0;
            col_q    <= '0;
            state_q  <= ST_FETCH;
          end
        end
        // mem_addr_q already holds the running index; one cycle covers the read latency.
        ST_FETCH: state_q <= ST_WRITE_CHAR;
        ST_WRITE_CHAR: begin
          if (!issued_q) begin
            issued_q      <= 1'b1;
            tx_start_q    <= 1'b1;
            tx_byte_q     <= mem_data;
            tx_rs_q       <= 1'b1;
            tx_nib_only_q <= 1'b0;
            tx_long_q     <= 1'b0;
          end else if (tx_done) begin
            issued_q   <= 1'b0;
            mem_addr_q <= mem_addr_q + 1'b1;
            if (col_q != 6'(COLS - 1)) begin
              col_q   <= col_q + 6'd1;
              state_q <= ST_FETCH;
            end else if (row_q != 1'(ROWS - 1)) begin
              row_q   <= 1'b1;
              state_q <= ST_SET_ADDR;
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_POWERUP;
      endcase
    end
  end

  lcd_nibble_tx #(
    .E_PULSE  (E_PULSE),
    .NIB_GAP  (NIB_GAP),
    .CMD_WAIT (CMD_WAIT),
    .CLR_WAIT (CLR_WAIT)
  ) u_tx (
    .clk_i         (clk),
    .reset_i       (reset),
    .start_i       (tx_start_q),
    .byte_i        (tx_byte_q),
    .rs_i          (tx_rs_q),
    .nibble_only_i (tx_nib_only_q),
    .long_wait_i   (tx_long_q),
    .nib_wait_i    (tx_nib_wait_q),
    .done_o        (tx_done),
    .lcd_e_o       (lcd_e),
    .lcd_rs_o      (lcd_rs),
    .sf_d_o        (sf_d)
  );

  assign mem_addr  = mem_addr_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;
  assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// tb/tb_lcd_text_ctrl.sv - directed bench for lcd_text_ctrl with shortened timing
module tb_lcd_text_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        refresh_req = 1'b0;
  logic [10:0] base_addr = '0;
  logic [10:0] mem_addr;
  logic [7:0]  mem_data = '0;
  logic        busy, init_done, lcd_e, lcd_rs, lcd_rw;
  logic [3:0]  sf_d;

  int tests_run = 0;
  int tests_failed = 0;

  logic [3:0]  p_d[$];
  logic        p_rs[$];
  logic [10:0] p_addr[$];
  logic        e_prev = 1'b0;
  logic [3:0]  cur_d = '0;
  logic        cur_rs = 1'b0;
  int          stab_err = 0;
  int          rw_err = 0;

  lcd_text_ctrl #(
    .ROWS(2), .COLS(4), .ADDR_W(11), .POWERUP_CYCLES(20), .E_PULSE(3), .NIB_GAP(4),
    .CMD_WAIT(10), .CLR_WAIT(30), .INIT_WAIT0(10), .INIT_WAIT1(10), .INIT_WAIT2(10), .INIT_WAIT3(10)
  ) dut (
    .clk(clk), .reset(reset), .refresh_req(refresh_req), .base_addr(base_addr),
    .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy), .init_done(init_done),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .sf_d(sf_d)
  );

  always #5 clk = ~clk;

  // Character memory holds the low byte of its own index.
  always @(posedge clk) mem_data <= mem_addr[7:0];

  always @(negedge clk) begin
    if (lcd_e === 1'b1 && e_prev === 1'b0) begin
      p_d.push_back(sf_d);
      p_rs.push_back(lcd_rs);
      p_addr.push_back(mem_addr);
      cur_d = sf_d;
      cur_rs = lcd_rs;
    end else if (lcd_e === 1'b1 && (sf_d !== cur_d || lcd_rs !== cur_rs)) begin
      stab_err++;
    end
    if (lcd_rw !== 1'b0) rw_err++;
    e_prev = lcd_e;
  end

  function automatic logic [7:0] byte_at(int idx);
    if (p_d.size() < idx + 2) return 8'hxx;
    return {p_d[idx], p_d[idx+1]};
  endfunction

  task automatic pulse_refresh();
    @(negedge clk) refresh_req = 1'b1;
    @(negedge clk) refresh_req = 1'b0;
  endtask

  task automatic wait_init_done(input string name);
    int n = 0;
    while (init_done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (init_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s: init_done timeout, got %b want 1", name, init_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run += 7;
    if (lcd_e !== 1'b0)      begin tests_failed++; $display("FAIL reset_e: got %b want 0", lcd_e); end
    if (lcd_rs !== 1'b0)     begin tests_failed++; $display("FAIL reset_rs: got %b want 0", lcd_rs); end
    if (lcd_rw !== 1'b0)     begin tests_failed++; $display("FAIL reset_rw: got %b want 0", lcd_rw); end
    if (sf_d !== 4'h0)       begin tests_failed++; $display("FAIL reset_sf_d: got %h want 0", sf_d); end
    if (mem_addr !== 11'h0)  begin tests_failed++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    if (busy !== 1'b1)       begin tests_failed++; $display("FAIL reset_busy: got %b want 1", busy); end
    if (init_done !== 1'b0)  begin tests_failed++; $display("FAIL reset_init_done: got %b want 0", init_done); end
  endtask

  task automatic check_init_seq(input int b0, input string name);
    logic [3:0] exp_n[4] = '{4'h3, 4'h3, 4'h3, 4'h2};
    logic [7:0] exp_b[4] = '{8'h28, 8'h06, 8'h0C, 8'h01};
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (p_d.size() <= b0 + k || p_d[b0+k] !== exp_n[k] || p_rs[b0+k] !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s_nibble%0d: got %h want %h rs=0", name, k,
                 (p_d.size() > b0 + k) ? p_d[b0+k] : 4'hx, exp_n[k]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (byte_at(b0 + 4 + 2*k) !== exp_b[k] || p_rs[b0+4+2*k] !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s_byte%0d: got %h want %h rs=0", name, k, byte_at(b0 + 4 + 2*k), exp_b[k]);
      end
    end
  endtask

  task automatic test_init();
    int b0 = p_d.size();
    @(negedge clk) reset = 1'b0;
    wait_init_done("init");
    tests_run += 2;
    if (p_d.size() - b0 !== 12) begin
      tests_failed++; $display("FAIL init_pulses: got %0d want 12", p_d.size() - b0);
    end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL init_busy: got %b want 0", busy); end
    check_init_seq(b0, "init");
  endtask

  task automatic test_refresh();
    logic [7:0] exp_b[10] = '{8'h80, 8'h10, 8'h11, 8'h12, 8'h13, 8'hC0, 8'h14, 8'h15, 8'h16, 8'h17};
    logic       exp_rs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int b0 = p_d.size();
    base_addr = 11'h010;
    pulse_refresh();
    repeat (500) @(negedge clk);
    tests_run += 2;
    if (p_d.size() - b0 !== 20) begin
      tests_failed++; $display("FAIL refresh_pulses: got %0d want 20", p_d.size() - b0);
    end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL refresh_busy: got %b want 0", busy); end
    for (int k = 0; k < 10; k++) begin
      tests_run++;
      if (byte_at(b0 + 2*k) !== exp_b[k] || p_rs[b0+2*k] !== exp_rs[k]) begin
        tests_failed++;
        $display("FAIL refresh_byte%0d: got %h rs=%b want %h rs=%b", k, byte_at(b0 + 2*k),
                 p_rs[b0+2*k], exp_b[k], exp_rs[k]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [10:0] exp_a[4] = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
    logic [7:0]  exp_c[4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    int b0 = p_d.size();
    base_addr = 11'h7FE;
    pulse_refresh();
    repeat (500) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (p_addr.size() <= b0 + 2 + 2*k || p_addr[b0+2+2*k] !== exp_a[k] ||
          byte_at(b0 + 2 + 2*k) !== exp_c[k]) begin
        tests_failed++;
        $display("FAIL wrap_char%0d: got addr %h data %h want addr %h data %h", k,
                 (p_addr.size() > b0 + 2 + 2*k) ? p_addr[b0+2+2*k] : 11'hx,
                 byte_at(b0 + 2 + 2*k), exp_a[k], exp_c[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int b0 = p_d.size();
    base_addr = 11'h010;
    pulse_refresh();
    repeat (20) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      pulse_refresh();
      repeat (5) @(negedge clk);
    end
    repeat (1500) @(negedge clk);
    tests_run += 3;
    if (p_d.size() - b0 !== 40) begin
      tests_failed++; $display("FAIL b2b_pulses: got %0d want 40", p_d.size() - b0);
    end
    if (byte_at(b0 + 20) !== 8'h80) begin
      tests_failed++; $display("FAIL b2b_second_start: got %h want 80", byte_at(b0 + 20));
    end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_busy: got %b want 0", busy); end
  endtask

  task automatic test_no_auto_refresh();
    int b0 = p_d.size();
    repeat (1200) @(negedge clk);
    tests_run++;
    if (p_d.size() - b0 !== 0) begin
      tests_failed++; $display("FAIL no_auto_refresh: got %0d pulses want 0", p_d.size() - b0);
    end
  endtask

  task automatic test_reset_mid_transfer();
    int b0 = p_d.size();
    int n = 0;
    base_addr = 11'h010;
    pulse_refresh();
    while (p_d.size() - b0 < 13 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (lcd_e !== 1'b1 || p_rs[b0+12] !== 1'b1) begin
      tests_failed++; $display("FAIL midreset_in_char: got e=%b want e=1 during 5th char", lcd_e);
    end
    reset = 1'b1;
    @(negedge clk);
    tests_run += 3;
    if (lcd_e !== 1'b0)     begin tests_failed++; $display("FAIL midreset_e: got %b want 0", lcd_e); end
    if (init_done !== 1'b0) begin tests_failed++; $display("FAIL midreset_init_done: got %b want 0", init_done); end
    if (busy !== 1'b1)      begin tests_failed++; $display("FAIL midreset_busy: got %b want 1", busy); end
    @(negedge clk);
    b0 = p_d.size();
    reset = 1'b0;
    repeat (4) @(negedge clk);
    pulse_refresh();
    wait_init_done("reinit");
    tests_run++;
    if (p_d.size() - b0 !== 12) begin
      tests_failed++; $display("FAIL reinit_pulses: got %0d want 12", p_d.size() - b0);
    end
    check_init_seq(b0, "reinit");
    repeat (600) @(negedge clk);
    tests_run += 2;
    if (p_d.size() - b0 !== 32) begin
      tests_failed++; $display("FAIL early_req_pulses: got %0d want 32", p_d.size() - b0);
    end
    if (byte_at(b0 + 12) !== 8'h80 || p_rs[b0+12] !== 1'b0) begin
      tests_failed++; $display("FAIL early_req_first: got %h want 80", byte_at(b0 + 12));
    end
  endtask

  task automatic test_bus_rules();
    tests_run += 2;
    if (stab_err !== 0) begin tests_failed++; $display("FAIL bus_stable: got %0d glitches want 0", stab_err); end
    if (rw_err !== 0)   begin tests_failed++; $display("FAIL rw_low: got %0d cycles high want 0", rw_err); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_refresh();
    test_wrap();
    test_back_to_back();
    test_no_auto_refresh();
    test_reset_mid_transfer();
    test_bus_rules();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lcd_text_ctrl.md
LCD_TEXT_CTRL -- requirements
Module: lcd_text_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ROWS, 2: displayed rows, legal 1..2
- COLS, 16: characters per row, legal 1..40
- ADDR_W, 11: character memory address width
- POWERUP_CYCLES, 750000: wait before first init nibble
- E_PULSE, 12: LCD E high time, cycles
- NIB_GAP, 50: E-low gap between high and low nibble
- CMD_WAIT, 2000: post-byte wait
- CLR_WAIT, 82000: post-clear (0x01) wait
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: single clock, all logic rising-edge
- reset, in, 1: synchronous, active-high
- refresh_req, in, 1: one-cycle pulse requesting a full screen rewrite
- base_addr, in, ADDR_W: first character index, sampled at refresh start
- mem_addr, out, ADDR_W: character memory read address
- mem_data, in, 8: read data, valid one cycle after mem_addr
- busy, out, 1: high except in IDLE
- init_done, out, 1: high once configuration completes, sticky until reset
- lcd_e, out, 1
- lcd_rs, out, 1
- lcd_rw, out, 1
- sf_d, out, 4: LCD data nibble

Function
REQ-003 States: POWERUP, INIT, CONFIG, IDLE, SET_ADDR, FETCH, WRITE_CHAR; the state after reset is POWERUP.
REQ-004 POWERUP shall wait POWERUP_CYCLES, then enter INIT.
REQ-005 INIT shall send the single nibbles 0x3, 0x3, 0x3, 0x2, each with rs=0, 2 setup cycles, then E_PULSE cycles of E high; the waits after these nibbles shall be 205000, 5000, 2000 and 2000 cycles respectively.
REQ-006 CONFIG shall send these bytes with rs=0: function set (0x28 if ROWS==2, 0x20 if ROWS==1), 0x06, 0x0C, 0x01; init_done shall rise when the 0x01 wait ends, and the state shall then be IDLE.
REQ-007 A byte transfer shall be sequenced as: high nibble with 2 setup cycles, E_PULSE cycles E high, then NIB_GAP cycles E low; then low nibble with 2 setup cycles and E_PULSE cycles E high; then a wait of CMD_WAIT cycles, or CLR_WAIT cycles when the byte is 0x01 with rs=0.
REQ-008 sf_d and lcd_rs shall stay stable from the start of setup until E falls.
REQ-009 lcd_rw shall be 0 at all times.
REQ-010 Refresh, for each row r in 0..ROWS-1: SET_ADDR shall send 0x80|(r*0x40) with rs=0; then, for each column c, FETCH shall drive mem_addr = base_addr + r*COLS + c (mod 2^ADDR_W), and WRITE_CHAR shall send mem_data with rs=1.
REQ-011 After the last character, the state shall return to IDLE.
REQ-012 refresh_req arriving while busy shall set a single pending flag, and that refresh shall start the cycle after IDLE is entered; further requests while the flag is set shall be dropped.
REQ-013 refresh_req arriving before init_done shall be held pending and serviced on the first entry to IDLE.

Reset
REQ-014 While reset is high: lcd_e=0, lcd_rs=0, lcd_rw=0, sf_d=0, mem_addr=0, busy=1, init_done=0, pending flag cleared, all counters 0, state POWERUP.
REQ-015 A reset asserted mid-transfer shall abort the transfer within one cycle and restart the full init sequence.

Configuration
REQ-016 When LCD_AUTO_REFRESH_EN is defined, parameter REFRESH_PERIOD (default 50000000) shall be added; an internal counter shall raise the pending flag every REFRESH_PERIOD cycles after init_done.
REQ-017 When LCD_AUTO_REFRESH_EN is not defined, refreshes shall occur only on refresh_req, and no auto-refresh counter shall exist.

Structure
REQ-018 A package lcd_pkg shall hold the state enum, the LCD command constants (0x28, 0x20, 0x06, 0x0C, 0x01, 0x80, 0x40) and the INIT wait constants.
REQ-019 Sub-module lcd_nibble_tx shall perform one nibble or byte transfer including the wait; it is started with a start pulse plus byte, rs, nibble_only and long_wait inputs, and returns a one-cycle done pulse.

Verification
Benches shall use small parameters: POWERUP_CYCLES=20, CMD_WAIT=10, CLR_WAIT=30, NIB_GAP=4, E_PULSE=3, with INIT waits overridden to 10.
REQ-020 Reset release -> exactly 4 E pulses carrying 0x3, 0x3, 0x3, 0x2, then bytes 0x28, 0x06, 0x0C, 0x01 (8 E pulses), then init_done=1 and busy=0.
REQ-021 ROWS=2, COLS=4, base_addr=0x10, memory = index LSBs, one refresh_req -> bytes 0x80, 0x10..0x13, 0xC0, 0x14..0x17 with rs=0 on the address bytes only.
REQ-022 base_addr=2^ADDR_W-2, COLS=4, ROWS=1 -> mem_addr sequence 0x7FE, 0x7FF, 0x000, 0x001.
REQ-023 Three refresh_req pulses during one refresh -> exactly one extra refresh follows.
REQ-024 reset pulse during the 5th character -> lcd_e=0 on the next cycle, init_done=0, and the full init sequence repeats.
REQ-025 With LCD_AUTO_REFRESH_EN defined and REFRESH_PERIOD=500 -> refreshes start 500 cycles apart with no refresh_req; without the macro -> no refresh after init.
